// File: rtl/pixel_queue.sv
// pixel_queue: first-word-fall-through coordinate queue between the pixel
// mapping stage and the engine distributor. Each entry holds a signed Q5.20
// complex coordinate plus its screen position. full_queue asserts while SLACK
// entries are still free, so a producer reacting one cycle late cannot overflow.
// Optional statistics (drop_count, high_water) are built only when the macro
// PIXEL_QUEUE_STATS_EN is defined; otherwise those ports are tied to zero.
module pixel_queue #(
  parameter int PIXEL_DATA_WIDTH  = 10,
  parameter int ENGINE_DATA_WIDTH = 25,
  parameter int DEPTH             = 16,
  parameter int SLACK             = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic                                wr_en,
  input  logic signed [ENGINE_DATA_WIDTH-1:0] wr_real_x,
  input  logic signed [ENGINE_DATA_WIDTH-1:0] wr_imag_y,
  input  logic        [PIXEL_DATA_WIDTH-1:0]  wr_pixel_x,
  input  logic        [PIXEL_DATA_WIDTH-1:0]  wr_pixel_y,
  output logic                                full_queue,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [ENGINE_DATA_WIDTH-1:0] out_real_x,
  output logic signed [ENGINE_DATA_WIDTH-1:0] out_imag_y,
  output logic        [PIXEL_DATA_WIDTH-1:0]  out_pixel_x,
  output logic        [PIXEL_DATA_WIDTH-1:0]  out_pixel_y,
  output logic        [$clog2(DEPTH):0]       count,
  output logic        [15:0]                  drop_count,
  output logic        [$clog2(DEPTH):0]       high_water
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int ENTRY_W = 2 * ENGINE_DATA_WIDTH + 2 * PIXEL_DATA_WIDTH;

  localparam logic [CW-1:0] CNT_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_FULLAT = CW'(DEPTH - SLACK);

  // Storage and control state
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q,  count_d;

  logic               pop;
  logic               push_ok;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

  // Handshake decode: a full queue still takes a write when the head leaves
  // in the same cycle, so a steady push/pop stream never stalls at DEPTH.
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign push_ok   = wr_en & ((count_q < CNT_DEPTH) | pop);

  // Back-pressure depends only on the registered occupancy.
  assign full_queue = (count_q >= CNT_FULLAT);
  assign count      = count_q;

  // Entry packing; values are stored bit-exact with no rounding.
  assign wr_entry   = {wr_real_x, wr_imag_y, wr_pixel_x, wr_pixel_y};
  assign head_entry = mem_q[rd_ptr_q];

  assign out_real_x  = head_entry[ENTRY_W-1 -: ENGINE_DATA_WIDTH];
  assign out_imag_y  = head_entry[ENTRY_W-ENGINE_DATA_WIDTH-1 -: ENGINE_DATA_WIDTH];
  assign out_pixel_x = head_entry[2*PIXEL_DATA_WIDTH-1 -: PIXEL_DATA_WIDTH];
  assign out_pixel_y = head_entry[PIXEL_DATA_WIDTH-1:0];

  // Next-state pointers and occupancy; flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry array; cleared on reset so the outputs read zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok && !flush) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

`ifdef PIXEL_QUEUE_STATS_EN
  logic [15:0]   drop_count_q;
  logic [CW-1:0] high_water_q;

  // Statistics: saturating drop counter and occupancy peak since reset/flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_q <= '0;
      high_water_q <= '0;
    end else begin
      if (wr_en && !push_ok && !flush && (drop_count_q != 16'hFFFF))
        drop_count_q <= drop_count_q + 16'd1;
      if (flush)
        high_water_q <= '0;
      else if (count_d > high_water_q)
        high_water_q <= count_d;
    end
  end

  assign drop_count = drop_count_q;
  assign high_water = high_water_q;
`else
  assign drop_count = '0;
  assign high_water = '0;
`endif

endmodule

// File: tb/tb_pixel_queue.sv
// Bench for pixel_queue: a queue-based reference model predicts every output
// each cycle; a vector table covers the first fill/pop sequence and
// hand-written sequences cover full, wrap, flush, reset and sign corners.
module tb_pixel_queue;

  localparam int PW    = 10;
  localparam int EW    = 25;
  localparam int DEPTH = 16;
  localparam int SLACK = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef PIXEL_QUEUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic signed [EW-1:0] rx;
    logic signed [EW-1:0] iy;
    logic [PW-1:0]        px;
    logic [PW-1:0]        py;
  } ent_t;

  typedef struct {
    logic                 wr;
    logic                 rdy;
    logic signed [EW-1:0] rx;
    logic [PW-1:0]        px;
    int                   exp_count;
    logic                 exp_valid;
    logic [PW-1:0]        exp_head_px;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset, flush, wr_en, out_ready;
  logic signed [EW-1:0] wr_real_x, wr_imag_y;
  logic [PW-1:0]        wr_pixel_x, wr_pixel_y;
  logic                 full_queue, out_valid;
  logic signed [EW-1:0] out_real_x, out_imag_y;
  logic [PW-1:0]        out_pixel_x, out_pixel_y;
  logic [CW-1:0]        count, high_water;
  logic [15:0]          drop_count;

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];
  int   drop_m = 0;
  int   hw_m   = 0;

  always #5 clk = ~clk;

  pixel_queue #(
    .PIXEL_DATA_WIDTH(PW), .ENGINE_DATA_WIDTH(EW), .DEPTH(DEPTH), .SLACK(SLACK)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en),
    .wr_real_x(wr_real_x), .wr_imag_y(wr_imag_y),
    .wr_pixel_x(wr_pixel_x), .wr_pixel_y(wr_pixel_y),
    .full_queue(full_queue), .out_valid(out_valid), .out_ready(out_ready),
    .out_real_x(out_real_x), .out_imag_y(out_imag_y),
    .out_pixel_x(out_pixel_x), .out_pixel_y(out_pixel_y),
    .count(count), .drop_count(drop_count), .high_water(high_water)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_drop();
    return STATS ? drop_m : 0;
  endfunction

  function automatic int exp_hw();
    return STATS ? hw_m : 0;
  endfunction

  task automatic set_wr(input logic en, input logic signed [EW-1:0] rx,
                        input logic signed [EW-1:0] iy, input logic [PW-1:0] px,
                        input logic [PW-1:0] py);
    wr_en = en; wr_real_x = rx; wr_imag_y = iy; wr_pixel_x = px; wr_pixel_y = py;
  endtask

  // Check outputs against the model, clock once, then advance the model.
  task automatic cycle();
    int   n;
    bit   pop, push;
    ent_t e;
    n = sb.size();
    chk("valid", out_valid, (n != 0));
    chk("count", count, n);
    chk("full", full_queue, (n >= DEPTH - SLACK));
    chk("drop", drop_count, exp_drop());
    chk("hwater", high_water, exp_hw());
    if (n != 0) begin
      chk("head_rx", out_real_x, sb[0].rx);
      chk("head_iy", out_imag_y, sb[0].iy);
      chk("head_px", out_pixel_x, sb[0].px);
      chk("head_py", out_pixel_y, sb[0].py);
    end
    pop  = (n != 0) && out_ready;
    push = wr_en && ((n < DEPTH) || pop);
    e    = '{rx: wr_real_x, iy: wr_imag_y, px: wr_pixel_x, py: wr_pixel_y};
    @(posedge clk);
    if (flush) begin
      sb.delete();
      hw_m = 0;
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back(e);
      else if (wr_en && drop_m != 16'hFFFF) drop_m++;
      if (sb.size() > hw_m) hw_m = sb.size();
    end
    #1;
  endtask

  vec_t vt[6];
  int   drop_before;

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_wr(1'b0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_full", full_queue, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_hw", high_water, 0);
    chk("rst_rx", out_real_x, 0);
    chk("rst_px", out_pixel_x, 0);

    // Vector table: three writes with ready low, then idle, pop, push+pop
    vt[0] = '{1'b1, 1'b0, 25'sh1F00000, 10'd0, 1, 1'b1, 10'd0};
    vt[1] = '{1'b1, 1'b0, 25'sh1F00001, 10'd1, 2, 1'b1, 10'd0};
    vt[2] = '{1'b1, 1'b0, 25'sh1F00002, 10'd2, 3, 1'b1, 10'd0};
    vt[3] = '{1'b0, 1'b0, 25'sh0000000, 10'd0, 3, 1'b1, 10'd0};
    vt[4] = '{1'b0, 1'b1, 25'sh0000000, 10'd0, 2, 1'b1, 10'd1};
    vt[5] = '{1'b1, 1'b1, 25'sh0012345, 10'd3, 2, 1'b1, 10'd2};
    for (int i = 0; i < 6; i++) begin
      set_wr(vt[i].wr, vt[i].rx, 25'sh0000100 + i, vt[i].px, 10'd7 + 10'(i));
      out_ready = vt[i].rdy;
      cycle();
      chk("vec_count", count, vt[i].exp_count);
      chk("vec_valid", out_valid, vt[i].exp_valid);
      chk("vec_head_px", out_pixel_x, vt[i].exp_head_px);
      if (i == 2) chk("vec_full3", full_queue, 0);
    end

    // Clear with flush
    set_wr(1'b0, '0, '0, '0, '0); out_ready = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;

    // Fill to DEPTH-SLACK, watch full_queue rise, then fill and overflow
    for (int i = 0; i < 14; i++) begin
      set_wr(1'b1, 25'sh0000200 + i, -25'sh0000010 - i, 10'(100 + i), 10'(500 + i));
      cycle();
      if (i == 12) chk("full_at13", full_queue, 0);
    end
    chk("full_at14", full_queue, 1);
    for (int i = 14; i < 16; i++) begin
      set_wr(1'b1, 25'sh0000200 + i, -25'sh0000010 - i, 10'(100 + i), 10'(500 + i));
      cycle();
    end
    chk("count16", count, 16);
    set_wr(1'b1, 25'sh0ABCDEF, 25'sh0000001, 10'd999, 10'd999);
    cycle();
    chk("count_after_drop", count, 16);
    chk("drop_one", drop_count, STATS ? 1 : 0);

    // Full queue, write and pop together
    chk("full_head_px", out_pixel_x, 100);
    set_wr(1'b1, 25'sh0000300, 25'sh0000301, 10'd200, 10'd201);
    out_ready = 1'b1;
    cycle();
    chk("full_pushpop_count", count, 16);
    chk("full_pushpop_head", out_pixel_x, 101);

    // Drain; the entry written while full must come out last
    set_wr(1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 15; i++) cycle();
    chk("last_px", out_pixel_x, 200);
    cycle();
    chk("drained", out_valid, 0);

    // Continuous push and pop, pointers wrap several times
    for (int i = 0; i < 40; i++) begin
      set_wr(1'b1, 25'(i * 4099), -25'(i * 17), 10'(300 + i), 10'(i));
      cycle();
    end
    set_wr(1'b0, '0, '0, '0, '0);
    cycle();
    chk("stream_empty", count, 0);

    // Flush with a coincident write and pop on a 5-entry queue
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_wr(1'b1, 25'sh0000040 + i, 25'sh0000050 + i, 10'(600 + i), 10'(i));
      cycle();
    end
    drop_before = exp_drop();
    set_wr(1'b1, 25'sh0000777, 25'sh0000777, 10'd777, 10'd777);
    out_ready = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0; set_wr(1'b0, '0, '0, '0, '0); out_ready = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_hw", high_water, 0);
    chk("flush_drop", drop_count, drop_before);

    // Negative coordinate round trip; hold ready low to check stability
    set_wr(1'b1, 25'sh1E00000, 25'sh1E80000, 10'd5, 10'd6);
    cycle();
    set_wr(1'b0, '0, '0, '0, '0);
    cycle();
    cycle();
    chk("neg_rx", out_real_x, 25'sh1E00000);
    chk("neg_iy", out_imag_y, 25'sh1E80000);
    out_ready = 1'b1;
    cycle();
    chk("neg_popped", out_valid, 0);

    // Reset during an active handshake
    out_ready = 1'b0;
    set_wr(1'b1, 25'sh0000123, 25'sh0000456, 10'd42, 10'd43);
    cycle();
    set_wr(1'b0, '0, '0, '0, '0);
    out_ready = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; out_ready = 1'b0;
    sb.delete(); drop_m = 0; hw_m = 0;
    chk("rst_hs_valid", out_valid, 0);
    chk("rst_hs_px", out_pixel_x, 0);
    chk("rst_hs_drop", drop_count, 0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_queue.md
# pixel_queue

Coordinate work queue between the pixel mapping stage and the engine distributor. Each cycle that the mapping stage presents a newly mapped point, the queue captures its complex coordinate (real_x, imag_y) together with its screen position (pixel_x, pixel_y). The queue presents those entries first-word-fall-through to the distributor under a valid/ready handshake. It drives full_queue back to the mapping stage early enough to absorb the point already in flight in that stage's output register.

## Interface
Parameters:
- PIXEL_DATA_WIDTH, 10, width of pixel_x / pixel_y
- ENGINE_DATA_WIDTH, 25, width of signed fixed-point real_x / imag_y (Q5.20)
- DEPTH, 16, entry count; power of two, ≥ 4
- SLACK, 2, free entries reserved when full_queue asserts; 1 ≤ SLACK < DEPTH

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (new frame / offset or zoom change)
- wr_en  in  1  one-cycle strobe: a new mapped point is on the wr_* data inputs
- wr_real_x  in  ENGINE_DATA_WIDTH  signed real coordinate
- wr_imag_y  in  ENGINE_DATA_WIDTH  signed imaginary coordinate
- wr_pixel_x  in  PIXEL_DATA_WIDTH  screen x
- wr_pixel_y  in  PIXEL_DATA_WIDTH  screen y
- full_queue  out  1  back-pressure to the mapping stage
- out_valid  out  1  head entry is valid
- out_ready  in  1  distributor accepts the head entry
- out_real_x, out_imag_y  out  ENGINE_DATA_WIDTH  head coordinate
- out_pixel_x, out_pixel_y  out  PIXEL_DATA_WIDTH  head pixel
- count  out  $clog2(DEPTH)+1  current occupancy
- drop_count  out  16  rejected writes (stats)
- high_water  out  $clog2(DEPTH)+1  maximum occupancy since reset or flush (stats)

## Operation
- Storage: DEPTH × (2·ENGINE_DATA_WIDTH + 2·PIXEL_DATA_WIDTH) register array, wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, and a separate count register.
- pop = out_valid & out_ready. Asserting out_ready while out_valid is low has no effect.
- push_ok = wr_en & (count < DEPTH | pop). A write to a full queue is accepted when a pop occurs in the same cycle.
- A write with wr_en high and push_ok low is dropped. Its data is not stored and no state changes except drop_count.
- Simultaneous push and pop: both pointers advance and count is unchanged.
- flush has priority over push and pop in the same cycle:
  - pointers and count go to 0;
  - high_water goes to 0;
  - the coincident write is discarded;
  - drop_count is retained.
- full_queue = (count ≥ DEPTH − SLACK). It is a combinational decode of the registered count, with no other combinational input path.
- out_valid = (count ≠ 0). out_* = mem[rd_ptr], read combinationally.
- Entries are delivered in strict write order and bit-exact. Signed values are stored unmodified, with no saturation or rounding.

## Timing
- Reset values:
  - count, pointers, full_queue, out_valid, drop_count, high_water all 0;
  - memory cleared to 0, so out_* read 0 after reset.
- Write-to-read latency is 1 cycle. A point written at edge N has out_valid high after edge N; it can be popped at edge N+1.
- Pop takes effect at the edge where out_valid & out_ready are both high. The next entry, if any, appears after that edge.
- full_queue reflects occupancy after the previous edge. With SLACK ≥ 1, a producer that samples full_queue one cycle late cannot overflow the queue.
- Reset or flush during an active handshake: the entry is lost, out_valid is 0 after the edge, and the distributor must not count that cycle as a transfer.
- Output data is stable while out_valid is high and out_ready is low.

## Configuration
- PIXEL_QUEUE_STATS_EN defined:
  - drop_count increments on every dropped write and saturates at 16'hFFFF;
  - high_water updates to count whenever count exceeds it.
- PIXEL_QUEUE_STATS_EN undefined: drop_count and high_water are tied to 0, no counter logic is instantiated, and the ports remain present.
- Queue function is identical in both builds.

## Test plan
- Reset, then write 3 points (real_x = 25'h1F00000 + i, pixel_x = i) with out_ready = 0 → count = 3, out_valid = 1, head pixel_x = 0, full_queue = 0.
- DEPTH = 16, SLACK = 2, write 14 entries without popping → full_queue rises after the 14th write edge. Two further writes are accepted (count = 16). A 17th write is dropped; drop_count = 1 with STATS_EN, 0 without.
- Full queue with wr_en and out_ready high in the same cycle → both accepted, count stays 16, popped entry is entry 0, the new entry appears last.
- Continuous push and pop for 40 cycles → pointers wrap at least twice and every out_pixel_x matches its write order exactly.
- Queue holding 5 entries, flush asserted together with wr_en and out_ready → count = 0, out_valid = 0, high_water = 0 with STATS_EN, drop_count unchanged.
- Negative coordinate round trip: write real_x = −2.0 (25'h1E00000), imag_y = −1.5 (25'h1E80000) → output bit-identical.
